prach_hb2_int_ch: RTL

- Half-band interpolate-by-2 filter for 32 TDM channels. It is the upsampling counterpart of the per-channel half-band decimator in the PRACH chain.
- Takes one 16-bit sample per channel per input slot and emits two polyphase output samples per slot on two ports:
  - filtered phase y[2n]
  - centre-tap phase y[2n+1]
- Sits ahead of the higher-rate stages on the PRACH transmit/test path.

---
 rtl/prach_hb2_int_ch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/prach_hb2_int_ch.sv
// Half-band interpolate-by-2 filter for TDM PRACH channels: emits the filtered
// phase y[2n] and the centre-tap phase y[2n+1] for every input sample.
module prach_hb2_int_ch #(
  parameter int NumChannel = 32,
  parameter int Latency    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] din_dq,
  input  logic               din_dv,
  input  logic [7:0]         din_chn,
  input  logic               sync_in,
  output logic signed [15:0] dout_dp1,
  output logic signed [15:0] dout_dp2,
  output logic               dout_dv,
  output logic [7:0]         dout_chn,
  output logic               sync_out
);

  localparam int ChnW = $clog2(NumChannel);
  localparam logic [7:0] NUM_CH = 8'(NumChannel);
  localparam logic signed [17:0] C0 = -18'sd4249;
  localparam logic signed [17:0] C1 = 18'sd37013;
  // 2^15 on the unscaled sum is the round-half-up offset for the >>16 below
  localparam logic signed [35:0] RND = 36'sd32768;

  function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
    logic signed [15:0] r;
    if (v > 36'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -36'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  logic signed [15:0] h1_r [NumChannel];
  logic signed [15:0] h2_r [NumChannel];
  logic signed [15:0] h3_r [NumChannel];

  logic                chn_ok_s;
  logic [ChnW-1:0]     idx_s;
  logic signed [15:0]  x_s, rd1_s, rd2_s, rd3_s;

  logic signed [15:0]  x0_r, x1_r, x2_r, x3_r;
  logic signed [16:0]  pa0_r, pa1_r;
  logic signed [34:0]  p0_r, p1_r;
  logic signed [35:0]  acc_r;
  logic signed [15:0]  ctr1_r, ctr2_r, ctr3_r;
  logic [9:0]          ctl_r [Latency];

  assign chn_ok_s = (din_chn < NUM_CH);
  assign idx_s    = din_chn[ChnW-1:0];

  // Stage-0 operand select: sync or an out-of-range channel forces zero history.
  always_comb begin
    x_s   = 16'sd0;
    rd1_s = 16'sd0;
    rd2_s = 16'sd0;
    rd3_s = 16'sd0;
    if (chn_ok_s) begin
      x_s = din_dq;
      if (!sync_in) begin
        rd1_s = h1_r[idx_s];
        rd2_s = h2_r[idx_s];
        rd3_s = h3_r[idx_s];
      end else begin
        rd1_s = 16'sd0;
        rd2_s = 16'sd0;
        rd3_s = 16'sd0;
      end
    end else begin
      x_s = 16'sd0;
    end
  end

  // Per-channel history shift; sync clears everything but still lands the new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumChannel; i++) begin
        h1_r[i] <= 16'sd0;
        h2_r[i] <= 16'sd0;
        h3_r[i] <= 16'sd0;
      end
    end else if (sync_in) begin
      for (int i = 0; i < NumChannel; i++) begin
        h1_r[i] <= 16'sd0;
        h2_r[i] <= 16'sd0;
        h3_r[i] <= 16'sd0;
      end
      if (din_dv && chn_ok_s) begin
        h1_r[idx_s] <= din_dq;
      end
    end else if (din_dv && chn_ok_s) begin
      h3_r[idx_s] <= h2_r[idx_s];
      h2_r[idx_s] <= h1_r[idx_s];
      h1_r[idx_s] <= din_dq;
    end
  end

  // Five-stage datapath: capture, pre-add, multiply, accumulate, saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r     <= 16'sd0;
      x1_r     <= 16'sd0;
      x2_r     <= 16'sd0;
      x3_r     <= 16'sd0;
      pa0_r    <= 17'sd0;
      pa1_r    <= 17'sd0;
      p0_r     <= 35'sd0;
      p1_r     <= 35'sd0;
      acc_r    <= 36'sd0;
      ctr1_r   <= 16'sd0;
      ctr2_r   <= 16'sd0;
      ctr3_r   <= 16'sd0;
      dout_dp1 <= 16'sd0;
      dout_dp2 <= 16'sd0;
    end else begin
      x0_r     <= x_s;
      x1_r     <= rd1_s;
      x2_r     <= rd2_s;
      x3_r     <= rd3_s;
      pa0_r    <= 17'(x0_r) + 17'(x3_r);
      pa1_r    <= 17'(x1_r) + 17'(x2_r);
      ctr1_r   <= x1_r;
      p0_r     <= 35'(C0) * 35'(pa0_r);
      p1_r     <= 35'(C1) * 35'(pa1_r);
      ctr2_r   <= ctr1_r;
      acc_r    <= 36'(p0_r) + 36'(p1_r) + RND;
      ctr3_r   <= ctr2_r;
      dout_dp1 <= sat16(acc_r >>> 16);
      dout_dp2 <= ctr3_r;
    end
  end

  // Control delay line keeps {sync, dv, chn} aligned with the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Latency; i++) begin
        ctl_r[i] <= 10'd0;
      end
    end else begin
      ctl_r[0] <= {sync_in, din_dv, din_chn};
      for (int i = 1; i < Latency; i++) begin
        ctl_r[i] <= ctl_r[i-1];
      end
    end
  end

  assign {sync_out, dout_dv, dout_chn} = ctl_r[Latency-1];

endmodule
